controller: RTL and testbench

- Main sequencing FSM of the LC3 datapath. Decodes the current instruction's opcode plus a branch-condition flag from `c_control`, and steps through fetch/decode/execute/memory/writeback/PC-update phases.
- Waits on the memory `complete` handshake in memory phases.
- Exposes the current state as a 4-bit code; the datapath derives its enables from this code.

---
 rtl/controller.sv | 132 +++++++++++++
 tb/tb_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// LC3 main sequencing FSM: walks each instruction through fetch, decode,
// execute/memory, register writeback and PC update. The current state code
// is the only output; the datapath derives all of its enables from it.
module controller (
    input  logic       clock,
    input  logic       reset,      // synchronous, active-low
    input  logic [5:0] c_control,  // [5:2] opcode, [1] branch taken, [0] unused
    input  logic       complete,   // memory access done
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH        = 4'd0,
        DECODE       = 4'd1,
        EXECUTE      = 4'd2,
        COMPUTE_ADDR = 4'd3,
        READ_MEM     = 4'd4,
        READ_INDIR   = 4'd5,
        WRITE_MEM    = 4'd6,
        UPDATE_REG   = 4'd7,
        UPDATE_PC    = 4'd8,
        BRANCH_PC    = 4'd9,
        HALT         = 4'd10
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_op;
    logic       w_br_taken;
    logic       w_unused;

    assign w_op       = c_control[5:2];
    assign w_br_taken = c_control[1];
    assign w_unused   = c_control[0];
    assign state      = r_state;

    // State register; reset wins over every transition, including HALT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode from current state, opcode, branch flag and complete.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (complete) w_next = DECODE;
            end
            DECODE: begin
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT, OP_LEA:         w_next = EXECUTE;
                    OP_LD, OP_LDR, OP_LDI,
                    OP_ST, OP_STR, OP_STI:                  w_next = COMPUTE_ADDR;
                    OP_BR:   w_next = w_br_taken ? BRANCH_PC : UPDATE_PC;
                    OP_JMP:  w_next = BRANCH_PC;
                    OP_JSR:  w_next = UPDATE_REG;
                    OP_TRAP: w_next = HALT;
                    OP_RTI, OP_RSV:                         w_next = UPDATE_PC;
                    default: w_next = UPDATE_PC;
                endcase
            end
            EXECUTE: begin
                w_next = UPDATE_REG;
            end
            COMPUTE_ADDR: begin
                case (w_op)
                    OP_LD, OP_LDR: w_next = READ_MEM;
                    OP_ST, OP_STR: w_next = WRITE_MEM;
                    OP_LDI, OP_STI: w_next = READ_INDIR;
                    // Opcode changed under us; abandon the instruction.
                    default:       w_next = FETCH;
                endcase
            end
            READ_INDIR: begin
                if (complete) begin
                    if (w_op == OP_LDI) begin
                        w_next = READ_MEM;
                    end else if (w_op == OP_STI) begin
                        w_next = WRITE_MEM;
                    end else begin
                        w_next = FETCH;
                    end
                end
            end
            READ_MEM: begin
                if (complete) w_next = UPDATE_REG;
            end
            WRITE_MEM: begin
                if (complete) w_next = UPDATE_PC;
            end
            UPDATE_REG: begin
                // JSR has saved R7 and now jumps; everything else just steps PC.
                w_next = (w_op == OP_JSR) ? BRANCH_PC : UPDATE_PC;
            end
            UPDATE_PC: begin
                w_next = FETCH;
            end
            BRANCH_PC: begin
                w_next = FETCH;
            end
            HALT: begin
                w_next = HALT;
            end
            // Codes 11-15 recover to FETCH.
            default: begin
                w_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the LC3 controller FSM: the driver pushes the
// hand-computed state expected after every clock edge, and a monitor pops and
// compares on the falling edge.
module tb_controller;

    logic       clock;
    logic       reset;
    logic [5:0] c_control;
    logic       complete;
    logic [3:0] state;

    int errors;
    int checks;
    logic [3:0] exp_q[$];
    bit driver_done;

    controller dut (
        .clock    (clock),
        .reset    (reset),
        .c_control(c_control),
        .complete (complete),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs, then record the state expected after the edge.
    task automatic step(input logic r, input logic [5:0] cc, input logic cm,
                        input logic [3:0] exp_state);
        reset     = r;
        c_control = cc;
        complete  = cm;
        @(posedge clock);
        #1;
        exp_q.push_back(exp_state);
    endtask

    // Hold a wait state for n cycles with complete low.
    task automatic hold(input logic [5:0] cc, input int n, input logic [3:0] s);
        for (int i = 0; i < n; i++) step(1'b1, cc, 1'b0, s);
    endtask

    // Monitor: compare each recorded expectation against the live state.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (state !== e) begin
                errors = errors + 1;
                $display("FAIL state check %0d at %0t: got %0d expected %0d",
                         checks, $time, state, e);
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        driver_done = 0;
        reset = 1'b0;
        c_control = 6'h00;
        complete = 1'b0;

        // Reset, then release with complete low: stays in FETCH.
        step(1'b0, 6'h00, 1'b0, 4'd0);
        step(1'b0, 6'h00, 1'b0, 4'd0);
        hold(6'h00, 3, 4'd0);

        // ADD with one-cycle complete pulse; then FETCH waits indefinitely.
        step(1'b1, 6'h04, 1'b1, 4'd1);
        step(1'b1, 6'h04, 1'b0, 4'd2);
        step(1'b1, 6'h04, 1'b0, 4'd7);
        step(1'b1, 6'h04, 1'b0, 4'd8);
        step(1'b1, 6'h04, 1'b0, 4'd0);
        hold(6'h04, 4, 4'd0);

        // AND with reserved bit set (bit 0 ignored), complete held high.
        step(1'b1, 6'h15, 1'b1, 4'd1);
        step(1'b1, 6'h15, 1'b1, 4'd2);
        step(1'b1, 6'h15, 1'b1, 4'd7);
        step(1'b1, 6'h15, 1'b1, 4'd8);
        step(1'b1, 6'h15, 1'b1, 4'd0);

        // LDI with 3 wait cycles in READ_INDIR and READ_MEM.
        step(1'b1, 6'h28, 1'b1, 4'd1);
        step(1'b1, 6'h28, 1'b0, 4'd3);
        step(1'b1, 6'h28, 1'b0, 4'd5);
        hold(6'h28, 3, 4'd5);
        step(1'b1, 6'h28, 1'b1, 4'd4);
        hold(6'h28, 3, 4'd4);
        step(1'b1, 6'h28, 1'b1, 4'd7);
        step(1'b1, 6'h28, 1'b0, 4'd8);
        step(1'b1, 6'h28, 1'b0, 4'd0);

        // STI with complete stuck high: one state per cycle, no skipping.
        step(1'b1, 6'h2C, 1'b1, 4'd1);
        step(1'b1, 6'h2C, 1'b1, 4'd3);
        step(1'b1, 6'h2C, 1'b1, 4'd5);
        step(1'b1, 6'h2C, 1'b1, 4'd6);
        step(1'b1, 6'h2C, 1'b1, 4'd8);
        step(1'b1, 6'h2C, 1'b1, 4'd0);

        // ST with one write wait.
        step(1'b1, 6'h0C, 1'b1, 4'd1);
        step(1'b1, 6'h0C, 1'b0, 4'd3);
        step(1'b1, 6'h0C, 1'b0, 4'd6);
        hold(6'h0C, 1, 4'd6);
        step(1'b1, 6'h0C, 1'b1, 4'd8);
        step(1'b1, 6'h0C, 1'b0, 4'd0);

        // LD with complete high on arrival at READ_MEM.
        step(1'b1, 6'h08, 1'b1, 4'd1);
        step(1'b1, 6'h08, 1'b0, 4'd3);
        step(1'b1, 6'h08, 1'b1, 4'd4);
        step(1'b1, 6'h08, 1'b1, 4'd7);
        step(1'b1, 6'h08, 1'b0, 4'd8);
        step(1'b1, 6'h08, 1'b0, 4'd0);

        // BR taken / not taken, JSR, JMP, RTI, reserved opcode.
        step(1'b1, 6'h02, 1'b1, 4'd1);
        step(1'b1, 6'h02, 1'b0, 4'd9);
        step(1'b1, 6'h02, 1'b0, 4'd0);
        step(1'b1, 6'h00, 1'b1, 4'd1);
        step(1'b1, 6'h00, 1'b0, 4'd8);
        step(1'b1, 6'h00, 1'b0, 4'd0);
        step(1'b1, 6'h10, 1'b1, 4'd1);
        step(1'b1, 6'h10, 1'b0, 4'd7);
        step(1'b1, 6'h10, 1'b0, 4'd9);
        step(1'b1, 6'h10, 1'b0, 4'd0);
        step(1'b1, 6'h30, 1'b1, 4'd1);
        step(1'b1, 6'h30, 1'b0, 4'd9);
        step(1'b1, 6'h30, 1'b0, 4'd0);
        step(1'b1, 6'h20, 1'b1, 4'd1);
        step(1'b1, 6'h20, 1'b0, 4'd8);
        step(1'b1, 6'h20, 1'b0, 4'd0);
        step(1'b1, 6'h34, 1'b1, 4'd1);
        step(1'b1, 6'h34, 1'b0, 4'd8);
        step(1'b1, 6'h34, 1'b0, 4'd0);

        // TRAP halts regardless of complete; reset held 2 edges recovers.
        step(1'b1, 6'h3C, 1'b1, 4'd1);
        step(1'b1, 6'h3C, 1'b0, 4'd10);
        step(1'b1, 6'h3C, 1'b1, 4'd10);
        step(1'b1, 6'h3C, 1'b0, 4'd10);
        step(1'b1, 6'h3C, 1'b1, 4'd10);
        step(1'b0, 6'h3C, 1'b1, 4'd0);
        step(1'b0, 6'h3C, 1'b1, 4'd0);
        step(1'b1, 6'h00, 1'b0, 4'd0);

        // Reset mid-LDI while in READ_MEM.
        step(1'b1, 6'h28, 1'b1, 4'd1);
        step(1'b1, 6'h28, 1'b0, 4'd3);
        step(1'b1, 6'h28, 1'b1, 4'd5);
        step(1'b1, 6'h28, 1'b1, 4'd4);
        step(1'b0, 6'h28, 1'b1, 4'd0);
        step(1'b1, 6'h28, 1'b0, 4'd0);

        driver_done = 1;
        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
        @(posedge clock);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
